// File: rtl/f1_start_decoder.sv
// F1 start-light decoder: checks the thermometer light build-up, detects lights out,
// and measures driver reaction time or flags a jump start.
module f1_start_decoder #(
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [7:0]         data_in,
    input  logic               trigger,
    output logic [3:0]         lit_count,
    output logic               lights_out,
    output logic               react_valid,
    output logic [TIMER_W-1:0] react_time,
    output logic               jump_start,
    output logic               seq_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUILD  = 2'd1,
        ARMED  = 2'd2,
        TIMING = 2'd3
    } state_t;

    localparam logic [TIMER_W-1:0] TIMER_MAX = {TIMER_W{1'b1}};
    localparam logic [TIMER_W-1:0] TIMER_ONE = {{(TIMER_W-1){1'b0}}, 1'b1};

    state_t             state_r, state_s;
    logic [7:0]         pat_r;
    logic               trig_q_r;
    logic [TIMER_W-1:0] timer_r, timer_s;
    logic               trig_ev_s;
    logic [7:0]         next_pat_s;
    logic               lights_s, valid_s, jump_s, err_s, clr_timer_s;

    function automatic logic [3:0] popcount8(input logic [7:0] p);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, p[i]};
        end
        return cnt;
    endfunction

    // Light count follows the last sampled pattern directly.
    always_comb begin
        lit_count = popcount8(pat_r);
    end

    // Next-state and pulse decode; a trigger event outranks any pattern transition.
    always_comb begin
        state_s     = state_r;
        lights_s    = 1'b0;
        valid_s     = 1'b0;
        jump_s      = 1'b0;
        err_s       = 1'b0;
        clr_timer_s = 1'b0;
        trig_ev_s   = trigger & ~trig_q_r;
        next_pat_s  = {pat_r[6:0], 1'b1};
        case (state_r)
            IDLE: begin
                if (en && (data_in == 8'h01)) begin
                    state_s = BUILD;
                end else if (en && (data_in != 8'h00)) begin
                    err_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            BUILD: begin
                if (trig_ev_s) begin
                    jump_s  = 1'b1;
                    state_s = IDLE;
                    if (en && (data_in != pat_r) && (data_in != next_pat_s)) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = 1'b0;
                    end
                end else if (!en || (data_in == pat_r)) begin
                    state_s = BUILD;
                end else if (data_in == next_pat_s) begin
                    if (next_pat_s == 8'hFF) begin
                        state_s = ARMED;
                    end else begin
                        state_s = BUILD;
                    end
                end else begin
                    err_s   = 1'b1;
                    state_s = IDLE;
                end
            end
            ARMED: begin
                if (trig_ev_s) begin
                    jump_s  = 1'b1;
                    state_s = IDLE;
                    if (en && (data_in != 8'hFF) && (data_in != 8'h00)) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = 1'b0;
                    end
                end else if (!en || (data_in == 8'hFF)) begin
                    state_s = ARMED;
                end else if (data_in == 8'h00) begin
                    lights_s    = 1'b1;
                    clr_timer_s = 1'b1;
                    state_s     = TIMING;
                end else begin
                    err_s   = 1'b1;
                    state_s = IDLE;
                end
            end
            TIMING: begin
                if (trig_ev_s) begin
                    valid_s = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = TIMING;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Reaction timer: free-running while timing, saturates instead of wrapping.
    always_comb begin
        timer_s = timer_r;
        if (clr_timer_s) begin
            timer_s = {TIMER_W{1'b0}};
        end else if ((state_r == TIMING) && (timer_r != TIMER_MAX)) begin
            timer_s = timer_r + TIMER_ONE;
        end else begin
            timer_s = timer_r;
        end
    end

    // State, pattern, trigger history and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            pat_r       <= 8'h00;
            trig_q_r    <= 1'b0;
            timer_r     <= {TIMER_W{1'b0}};
            react_time  <= {TIMER_W{1'b0}};
            lights_out  <= 1'b0;
            react_valid <= 1'b0;
            jump_start  <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            state_r     <= state_s;
            trig_q_r    <= trigger;
            timer_r     <= timer_s;
            lights_out  <= lights_s;
            react_valid <= valid_s;
            jump_start  <= jump_s;
            seq_err     <= seq_err | err_s;
            if (en) begin
                pat_r <= data_in;
            end
            if (valid_s) begin
                react_time <= timer_r;
            end
        end
    end

endmodule

// File: tb/tb_f1_start_decoder.sv
// Self-checking bench for f1_start_decoder: vector table, directed corner
// sequences and biased random stimulus against a light-count/elapsed-time model.
module tb_f1_start_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        trigger = 1'b0;
    logic [3:0]  lit_count, lit_count4;
    logic        lights_out, react_valid, jump_start, seq_err;
    logic        lights_out4, react_valid4, jump_start4, seq_err4;
    logic [15:0] react_time;
    logic [3:0]  react_time4;

    f1_start_decoder #(.TIMER_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .trigger(trigger),
        .lit_count(lit_count), .lights_out(lights_out), .react_valid(react_valid),
        .react_time(react_time), .jump_start(jump_start), .seq_err(seq_err)
    );

    f1_start_decoder #(.TIMER_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .trigger(trigger),
        .lit_count(lit_count4), .lights_out(lights_out4), .react_valid(react_valid4),
        .react_time(react_time4), .jump_start(jump_start4), .seq_err(seq_err4)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;

    // reference model: lvl = lights lit so far in a legal build-up
    bit m_active, m_timing, m_prev_trig, m_lo, m_rv, m_js, m_err;
    int m_lvl, m_elapsed, m_pat, m_react;

    function automatic int thermo(input int n);
        return (1 << n) - 1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_timing = 0; m_prev_trig = 0;
        m_lo = 0; m_rv = 0; m_js = 0; m_err = 0;
        m_lvl = 0; m_elapsed = 0; m_pat = 0; m_react = 0;
    endtask

    task automatic model_step(input bit e, input int d, input bit t);
        bit ev, hold, stp, out, bad;
        ev = t && !m_prev_trig;
        m_lo = 0; m_rv = 0; m_js = 0;
        if (m_timing) begin
            if (ev) begin
                m_react  = (m_elapsed > 65535) ? 65535 : m_elapsed;
                m_rv     = 1;
                m_timing = 0;
            end else begin
                m_elapsed++;
            end
        end else if (m_active) begin
            hold = e && (d == thermo(m_lvl));
            stp  = e && (m_lvl < 8) && (d == thermo(m_lvl + 1));
            out  = e && (m_lvl == 8) && (d == 0);
            bad  = e && !(hold || stp || out);
            if (bad) m_err = 1;
            if (ev) begin
                m_js = 1; m_active = 0;
            end else if (bad) begin
                m_active = 0;
            end else if (stp) begin
                m_lvl++;
            end else if (out) begin
                m_active = 0; m_timing = 1; m_elapsed = 0; m_lo = 1;
            end
        end else if (e) begin
            if (d == 1) begin
                m_active = 1; m_lvl = 1;
            end else if (d != 0) begin
                m_err = 1;
            end
        end
        if (e) m_pat = d;
        m_prev_trig = t;
    endtask

    task automatic compare_all();
        check("lit_count", int'(lit_count), $countones(m_pat[7:0]));
        check("lights_out", int'(lights_out), int'(m_lo));
        check("react_valid", int'(react_valid), int'(m_rv));
        check("jump_start", int'(jump_start), int'(m_js));
        check("seq_err", int'(seq_err), int'(m_err));
        check("react_time", int'(react_time), m_react);
    endtask

    task automatic step(input logic e, input logic [7:0] d, input logic t);
        en = e; data_in = d; trigger = t;
        @(posedge clk);
        #1;
        model_step(e, int'(d), t);
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; data_in = 8'h00; trigger = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        compare_all();
        rst = 1'b0;
    endtask

    task automatic run_to_out();
        logic [7:0] p;
        step(1'b1, 8'h00, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            p = 8'(thermo(i));
            step(1'b1, p, 1'b0);
        end
        step(1'b1, 8'h00, 1'b0);
    endtask

    typedef struct {
        logic        en;
        logic [7:0]  d;
        logic        trig;
        logic [3:0]  lit;
        logic        lo, rv, js, err;
        logic [15:0] react;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic e, input logic [7:0] d, input logic t, input logic [3:0] lit,
                       input logic lo, input logic rv, input logic js, input logic err,
                       input logic [15:0] react);
        vec_t v;
        v.en = e; v.d = d; v.trig = t; v.lit = lit;
        v.lo = lo; v.rv = rv; v.js = js; v.err = err; v.react = react;
        tbl.push_back(v);
    endtask

    initial begin
        logic [7:0] p;
        int         pulses;
        // full legal run, trigger event on the 6th edge after lights out
        for (int i = 0; i <= 8; i++) begin
            p = 8'(thermo(i));
            add(1'b1, p, 1'b0, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        end
        add(1'b1, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 5; i++) add(1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        add(1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd5);
        add(1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5);
        // jump start at 0x07
        add(1'b1, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5);
        add(1'b1, 8'h01, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5);
        add(1'b1, 8'h03, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5);
        add(1'b1, 8'h07, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5);
        add(1'b0, 8'h00, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5);
        add(1'b0, 8'h00, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5);
        add(1'b1, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5);
        // illegal 0x01 -> 0x05
        add(1'b1, 8'h01, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5);
        add(1'b1, 8'h05, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'd5);
        add(1'b1, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd5);

        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].d, tbl[i].trig);
            check("tbl_lit", int'(lit_count), int'(tbl[i].lit));
            check("tbl_lights_out", int'(lights_out), int'(tbl[i].lo));
            check("tbl_react_valid", int'(react_valid), int'(tbl[i].rv));
            check("tbl_jump_start", int'(jump_start), int'(tbl[i].js));
            check("tbl_seq_err", int'(seq_err), int'(tbl[i].err));
            check("tbl_react_time", int'(react_time), int'(tbl[i].react));
        end

        // seq_err stays set through a legal run, clears only on reset
        run_to_out();
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("err_sticky", int'(seq_err), 1);
        check("sticky_react", int'(react_time), 1);
        step(1'b0, 8'h00, 1'b0);
        do_reset();
        check("err_cleared", int'(seq_err), 0);

        // holds with en gaps
        pulses = 0;
        for (int i = 0; i <= 8; i++) begin
            p = 8'(thermo(i));
            for (int k = 0; k < 3; k++) begin
                step(1'b1, p, 1'b0);
                step(1'b0, 8'h00, 1'b0);
            end
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 8'h00, 1'b0);
            pulses += int'(lights_out);
            step(1'b0, 8'h00, 1'b0);
            pulses += int'(lights_out);
        end
        check("hold_lights_pulses", pulses, 1);
        check("hold_no_err", int'(seq_err), 0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // trigger event during the lights_out cycle gives zero reaction time
        do_reset();
        run_to_out();
        step(1'b0, 8'h00, 1'b1);
        check("react_zero_valid", int'(react_valid), 1);
        check("react_zero_time", int'(react_time), 0);
        step(1'b0, 8'h00, 1'b0);

        // lights out and trigger event on the same edge in ARMED
        do_reset();
        step(1'b1, 8'h00, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            p = 8'(thermo(i));
            step(1'b1, p, 1'b0);
        end
        step(1'b1, 8'h00, 1'b1);
        check("simul_jump", int'(jump_start), 1);
        check("simul_no_lights", int'(lights_out), 0);
        step(1'b0, 8'h00, 1'b0);
        check("simul_no_lights_late", int'(lights_out), 0);

        // illegal pattern and trigger event together in BUILD
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h03, 1'b0);
        step(1'b1, 8'h0A, 1'b1);
        check("bad_trig_err", int'(seq_err), 1);
        check("bad_trig_jump", int'(jump_start), 1);
        step(1'b0, 8'h00, 1'b0);

        // saturation: 40 idle edges then trigger event
        do_reset();
        run_to_out();
        for (int i = 0; i < 40; i++) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("sat4_valid", int'(react_valid4), 1);
        check("sat4_time", int'(react_time4), 15);
        check("sat16_time", int'(react_time), 40);
        step(1'b0, 8'h00, 1'b0);

        // async reset mid-TIMING, observed before any clock edge
        do_reset();
        run_to_out();
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        run_to_out();
        step(1'b0, 8'h00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_lit", int'(lit_count), 0);
        check("arst_lights", int'(lights_out), 0);
        check("arst_valid", int'(react_valid), 0);
        check("arst_jump", int'(jump_start), 0);
        check("arst_err", int'(seq_err), 0);
        check("arst_time", int'(react_time), 0);
        check("arst_time4", int'(react_time4), 0);
        do_reset();
        step(1'b1, 8'h00, 1'b0);

        // biased random stimulus against the model
        for (int blk = 0; blk < 5; blk++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                logic       e, t;
                logic [7:0] d;
                int         r;
                r = int'($urandom_range(0, 15));
                e = ($urandom_range(0, 4) != 0);
                if (m_timing) begin
                    d = 8'($urandom);
                    t = ($urandom_range(0, 7) == 0);
                end else if (m_active) begin
                    if (r < 4) d = 8'(thermo(m_lvl));
                    else if (r < 14) d = (m_lvl == 8) ? 8'h00 : 8'(thermo(m_lvl + 1));
                    else d = 8'($urandom);
                    t = ($urandom_range(0, 29) == 0);
                end else begin
                    if (r < 6) d = 8'h00;
                    else if (r < 14) d = 8'h01;
                    else d = 8'($urandom);
                    t = ($urandom_range(0, 29) == 0);
                end
                step(e, d, t);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/f1_start_decoder.md
F1_START_DECODER -- requirements
Module: f1_start_decoder

Interface
REQ-001 Parameter: TIMER_W, 16, width of reaction-time counter (legal range 4..32).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  sample strobe; data_in is valid and sampled on edges where en=1.
REQ-005 data_in  input  8  start-light pattern from the light sequencer (bit i = light i lit).
REQ-006 trigger  input  1  driver button, synchronous level; an event is a rising edge (1 now, 0 on previous edge).
REQ-007 lit_count  output  4  number of lit lights in the last sampled pattern, 0..8.
REQ-008 lights_out  output  1  one-cycle pulse: start signal (0xFF -> 0x00 transition decoded).
REQ-009 react_valid  output  1  one-cycle pulse: react_time updated.
REQ-010 react_time  output  TIMER_W  cycles from lights_out to trigger event; holds until next update.
REQ-011 jump_start  output  1  one-cycle pulse: trigger event before lights out.
REQ-012 seq_err  output  1  sticky flag: illegal light pattern or transition seen.

Function
REQ-013 Pattern register P shall load data_in on every edge with en=1, in every state; lit_count shall be popcount(P), combinational from P.
REQ-014 Legal sequence shall be thermometer: 0x00, 0x01, 0x03, 0x07, ... 0xFF, then 0x00; repeated samples of the same pattern (hold) shall be legal.
REQ-015 States: IDLE, BUILD, ARMED, TIMING; all outputs registered.
REQ-016 IDLE: en with 0x00 -> stay; en with 0x01 -> BUILD; en with any other value -> set seq_err, stay IDLE.
REQ-017 BUILD: en with P (hold) -> stay; en with (P<<1)|1 where result != 0xFF -> stay; result == 0xFF -> ARMED; any other value -> set seq_err, go IDLE.
REQ-018 ARMED: en with 0xFF -> stay; en with 0x00 -> assert lights_out next cycle, clear timer to 0, go TIMING; any other value -> set seq_err, go IDLE.
REQ-019 TIMING: timer shall increment by 1 on every clk edge (not gated by en), saturating at 2^TIMER_W-1; data_in is not legality-checked.
REQ-020 Trigger event in TIMING: react_time <= timer value before increment, react_valid pulse, go IDLE; event in the cycle lights_out is high yields react_time=0.
REQ-021 Trigger event in BUILD or ARMED: jump_start pulse, go IDLE, react_time unchanged.
REQ-022 Trigger event in IDLE: ignored, no output.
REQ-023 Simultaneous in ARMED: en with 0x00 and trigger event on same edge -> jump_start only, lights_out not asserted, go IDLE.
REQ-024 Simultaneous in BUILD/ARMED: illegal pattern and trigger event on same edge -> seq_err set and jump_start pulse, go IDLE.
REQ-025 Timer saturation: stays at 2^TIMER_W-1 in TIMING until trigger event; react_time then equals 2^TIMER_W-1.
REQ-026 seq_err shall clear only on rst.
REQ-027 Pulses (lights_out, react_valid, jump_start) shall be high for exactly one clk cycle per event.

Reset
REQ-028 rst=1 shall immediately force: state IDLE, P=0x00, lit_count=0, timer=0, react_time=0, lights_out=0, react_valid=0, jump_start=0, seq_err=0, trigger history=0.
REQ-029 Reset mid-sequence (any state) shall abandon the sequence with no pulse generated; first edge after release behaves as IDLE.

Verification
REQ-030 Full legal run: en each cycle with 0x00,0x01,0x03,...,0xFF,0x00; trigger rises 5 cycles after lights_out -> lit_count tracks 0..8..0, one lights_out pulse, react_valid with react_time=5, seq_err=0.
REQ-031 Jump start: sequence to 0x07, trigger rise -> jump_start pulse, state IDLE, react_time unchanged, no lights_out.
REQ-032 Illegal pattern: 0x01 then 0x05 -> seq_err=1 and stays 1 after subsequent legal full run; rst clears it.
REQ-033 Holds and gaps: each pattern repeated 3x with en=0 gaps between -> no seq_err, normal lights_out.
REQ-034 Saturation with TIMER_W=4: lights_out, trigger after 40 cycles -> react_time=15.
REQ-035 Corner: 0x00 sample and trigger rise on same edge in ARMED -> jump_start=1, lights_out=0; async rst mid-TIMING -> all outputs 0 without clk edge.
